icache_fill: RTL and testbench

Line-refill engine sitting directly upstream of the instruction cache. When the cache raises `pull`, it fetches the missing line from an external quad-SPI-style nibble-wide flash. It buffers the nibbles, then replays them to the cache on `dread`/`wstrobe_d` as one contiguous 8-cycle burst. The cache's write-offset counter resets whenever `wstrobe_d` drops, so the burst must never have gaps.

---
 rtl/icache_fill.sv | 143 ++++++++++++++
 tb/tb_icache_fill.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
// Line-refill engine: fetches one 4-byte line from a nibble-wide quad-SPI flash
// and replays it to the instruction cache as a gap-free 8-nibble write burst.
module icache_fill #(
    parameter int         PA          = 22,
    parameter int         LINE_LENGTH = 4,
    parameter int         DUMMY       = 4,
    parameter logic [7:0] CMD         = 8'hEB
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pull,
    input  logic [PA-3:0] tag,
    output logic [3:0]    dread,
    output logic          wstrobe_d,
    output logic          busy,
    output logic          cs_n,
    output logic          sck,
    output logic [3:0]    io_out,
    output logic          io_oe,
    input  logic [3:0]    io_in
);

    localparam int NIBBLES = 2 * LINE_LENGTH;
    localparam int CW      = $clog2((DUMMY > 8) ? DUMMY : 8);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_BURST
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_phase, w_phase_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [CW-1:0]   w_last;
    logic [PA-3:0]   r_addr;
    logic [3:0]      r_line [NIBBLES];
    logic [23:0]     w_addr24;
    logic [23:0]     w_addr_sh;

    assign w_addr24  = 24'({r_addr, 2'b00});
    assign w_addr_sh = w_addr24 << {r_cnt, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Slot index of the final slot in each serial state
    always_comb begin
        w_last = '0;
        case (r_state)
            S_CMD:   w_last = CW'(1);
            S_ADDR:  w_last = CW'(5);
            S_DUMMY: w_last = CW'(DUMMY - 1);
            S_DATA:  w_last = CW'(NIBBLES - 1);
            S_BURST: w_last = CW'(NIBBLES - 1);
            default: w_last = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (pull) w_state_nxt = S_CMD;
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    if (r_cnt == w_last) begin
                        w_cnt_nxt = '0;
                        case (r_state)
                            S_CMD:   w_state_nxt = S_ADDR;
                            S_ADDR:  w_state_nxt = S_DUMMY;
                            S_DUMMY: w_state_nxt = S_DATA;
                            default: w_state_nxt = S_BURST;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            S_BURST: begin
                if (r_cnt == w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Flash sends high nibble first; the cache wants the low nibble at even positions
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && pull) r_addr <= tag;
        if (r_state == S_DATA && r_phase) r_line[r_cnt[2:0] ^ 3'd1] <= io_in;
    end

    always_comb begin
        cs_n      = 1'b1;
        sck       = 1'b0;
        io_out    = 4'h0;
        io_oe     = 1'b0;
        dread     = 4'h0;
        wstrobe_d = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_CMD: begin
                cs_n   = 1'b0;
                sck    = r_phase;
                io_oe  = 1'b1;
                io_out = (r_cnt == '0) ? CMD[7:4] : CMD[3:0];
            end
            S_ADDR: begin
                cs_n   = 1'b0;
                sck    = r_phase;
                io_oe  = 1'b1;
                io_out = w_addr_sh[23:20];
            end
            S_DUMMY, S_DATA: begin
                cs_n = 1'b0;
                sck  = r_phase;
            end
            S_BURST: begin
                wstrobe_d = 1'b1;
                dread     = r_line[r_cnt[2:0]];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: flash and cache behaviour modelled per clock as a
// function of the cycle number since the miss was sampled.
module tb_icache_fill;

    localparam int PA    = 22;
    localparam int DUMMY = 4;
    localparam int SER   = 2 * (16 + DUMMY);
    localparam int LAST  = SER + 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pull;
    logic [PA-3:0] tag;
    logic [3:0]    dread;
    logic          wstrobe_d;
    logic          busy;
    logic          cs_n;
    logic          sck;
    logic [3:0]    io_out;
    logic          io_oe;
    logic [3:0]    io_in;

    int checks = 0;
    int errors = 0;

    icache_fill #(.PA(PA), .LINE_LENGTH(4), .DUMMY(DUMMY), .CMD(8'hEB)) dut (
        .clk(clk), .reset(reset), .pull(pull), .tag(tag),
        .dread(dread), .wstrobe_d(wstrobe_d), .busy(busy),
        .cs_n(cs_n), .sck(sck), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] tg;
        logic [31:0] bytes;   // byte k at bits [8k+7:8k]
        logic [31:0] hdr;     // CMD + address nibbles, first on the wire at MSB
        logic [31:0] seq;     // dread burst, first strobe at MSB
        logic [31:0] word;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [12:0] observe();
        return {cs_n, sck, io_oe, io_out, wstrobe_d, dread, busy};
    endfunction

    // Expected outputs at cycle t after the miss (t outside 1..LAST means idle)
    function automatic logic [12:0] model(input int t, input logic [19:0] tg, input logic [31:0] bytes);
        logic [31:0] hdr;
        logic [3:0]  nib;
        int          s;
        hdr = {8'hEB, 2'b00, tg, 2'b00};
        if (t >= 1 && t <= SER) begin
            s   = (t - 1) / 2;
            nib = (s < 8) ? 4'(hdr >> (28 - 4 * s)) : 4'h0;
            return {1'b0, 1'((t - 1) % 2), (s < 8), nib, 1'b0, 4'h0, 1'b1};
        end else if (t > SER && t <= LAST) begin
            return {1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'(bytes >> (4 * (t - SER - 1))), 1'b1};
        end
        return {1'b1, 12'h000};
    endfunction

    // Flash drives valid data only while sck is high in a data slot
    function automatic logic [3:0] flash(input int t, input logic [31:0] bytes);
        int s, j;
        s = (t - 1) / 2;
        j = s - (8 + DUMMY);
        if (t >= 1 && t <= SER && (t - 1) % 2 == 1 && j >= 0 && j < 8)
            return 4'(bytes >> (8 * (j / 2) + ((j % 2 == 0) ? 4 : 0)));
        return 4'($urandom);
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            io_in = 4'($urandom);
            check("idle", 32'(observe()), 32'(model(0, 20'h0, 32'h0)));
        end
    endtask

    task automatic run_txn(input logic [19:0] tg, input logic [31:0] bytes,
                           input int drop_at, input int abort_at,
                           output logic [31:0] hdr_got, output logic [31:0] seq_got,
                           output logic [31:0] word_got, output int nstrobe,
                           output int ncs_hi, output int noe_late);
        hdr_got = '0; seq_got = '0; word_got = '0;
        nstrobe = 0; ncs_hi = 0; noe_late = 0;
        pull = 1'b1;
        tag  = tg;
        for (int t = 1; t <= LAST + 1; t++) begin
            @(posedge clk); #1;
            if (t == drop_at) pull = 1'b0;
            io_in = flash(t, bytes);
            check($sformatf("cycle%0d", t), 32'(observe()), 32'(model(t, tg, bytes)));
            if (t <= 16 && sck == 1'b0) hdr_got = {hdr_got[27:0], io_out};
            if (t > 16 && t <= SER && io_oe) noe_late++;
            if (t > SER && cs_n) ncs_hi++;
            if (wstrobe_d) begin
                seq_got = {seq_got[27:0], dread};
                if (nstrobe < 8) word_got[4 * nstrobe +: 4] = dread;
                nstrobe++;
            end
            if (t == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_wstrobe", 32'(wstrobe_d), 32'd0);
                check("abort_cs_n", 32'(cs_n), 32'd1);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_outs", 32'({sck, io_oe, io_out, dread}), 32'd0);
                pull = 1'b0;
                #2 reset = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        vec_t        tbl [3];
        logic [31:0] hdr_got, seq_got, word_got, tb_bytes;
        logic [19:0] tb_tag;
        int          nstrobe, ncs_hi, noe_late, noe_b;

        tbl[0] = '{20'h12345, 32'h44332211, 32'hEB048D14, 32'h11223344, 32'h44332211};
        tbl[1] = '{20'hABCDE, 32'h96C30FA5, 32'hEB2AF378, 32'h5AF03C69, 32'h96C30FA5};
        tbl[2] = '{20'hFFFFF, 32'hEF12FF00, 32'hEB3FFFFC, 32'h00FF21FE, 32'hEF12FF00};

        reset = 1'b1; pull = 1'b0; tag = '0; io_in = 4'h0;
        #1 reset = 1'b0;
        #1 check("reset_outputs", 32'(observe()), 32'(model(0, 20'h0, 32'h0)));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            tag   = 20'($urandom);
            io_in = 4'($urandom);
            check("idle_no_pull", 32'(observe()), 32'(model(0, 20'h0, 32'h0)));
        end

        for (int i = 0; i < 3; i++) begin
            run_txn(tbl[i].tg, tbl[i].bytes, LAST, -1, hdr_got, seq_got, word_got, nstrobe, ncs_hi, noe_late);
            check($sformatf("vec%0d_hdr", i), hdr_got, tbl[i].hdr);
            check($sformatf("vec%0d_burst", i), seq_got, tbl[i].seq);
            check($sformatf("vec%0d_word", i), word_got, tbl[i].word);
            check($sformatf("vec%0d_strobes", i), 32'(nstrobe), 32'd8);
            idle_cycles(1);
        end

        run_txn(20'h0F0F0, 32'hDEADBEEF, 10, -1, hdr_got, seq_got, word_got, nstrobe, ncs_hi, noe_late);
        check("drop_strobes", 32'(nstrobe), 32'd8);
        check("drop_word", word_got, 32'hDEADBEEF);
        idle_cycles(2);

        run_txn(20'h33333, 32'h01234567, -1, -1, hdr_got, seq_got, word_got, nstrobe, ncs_hi, noe_late);
        check("b2b_cs_high", 32'(ncs_hi), 32'd9);
        run_txn(20'h44444, 32'h89ABCDEF, LAST, -1, hdr_got, seq_got, word_got, nstrobe, ncs_hi, noe_b);
        check("b2b_oe_low", 32'(noe_late + noe_b), 32'd0);
        check("b2b_hdr", hdr_got, 32'hEB111110);
        check("b2b_word", word_got, 32'h89ABCDEF);
        idle_cycles(2);

        run_txn(20'h55555, 32'hCAFEF00D, -1, SER + 4, hdr_got, seq_got, word_got, nstrobe, ncs_hi, noe_late);
        check("abort_partial_strobes", 32'(nstrobe), 32'd4);
        idle_cycles(3);

        for (int i = 0; i < 8; i++) begin
            idle_cycles($urandom_range(0, 3));
            tb_tag   = 20'($urandom);
            tb_bytes = $urandom;
            run_txn(tb_tag, tb_bytes, LAST, -1, hdr_got, seq_got, word_got, nstrobe, ncs_hi, noe_late);
            check("rand_word", word_got, tb_bytes);
            check("rand_hdr", hdr_got, {8'hEB, 2'b00, tb_tag, 2'b00});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
